// File: rtl/convolutor_pkg.sv
// Shared types and constants for the convolutor ROM reader.
package convolutor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned OCCW      = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/convolutor_rom_reader_fifo2.sv
// Two-entry FIFO of {last, data} that absorbs stream backpressure for the ROM reader.
module convolutor_rom_reader_fifo2
    import convolutor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             push_last,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [OCCW-1:0]  occ
);

    logic [WIDTH:0] mem [BUF_DEPTH];
    logic           wr_ptr;
    logic           rd_ptr;

    // NOTE: the two entries are reset so that data_o reads zero out of reset;
    // a deep memory would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + OCCW'(push) - OCCW'(pop);
        end
    end

    assign {head_last, head_data} = mem[rd_ptr];

endmodule

// File: rtl/convolutor_rom_reader.sv
// Block reader for convolutor_simple_rom_p: sequences ROM addresses and streams words out.
// Optional abort input enabled by defining CONV_ROM_READER_ABORT_EN.
module convolutor_rom_reader
    import convolutor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDRW = $clog2(DEPTH),
    parameter int LENW  = ADDRW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [ADDRW-1:0] base_addr_i,
    input  logic [LENW-1:0]  length_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ADDRW-1:0] rom_addr_o,
    input  logic [WIDTH-1:0] rom_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             last_o,
`ifdef CONV_ROM_READER_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             ready_i
);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q;
    logic [LENW-1:0]  words_left_q;
    logic             inflight_q;
    logic             inflight_last_q;
    logic [OCCW-1:0]  occ;
    logic [WIDTH-1:0] head_data;
    logic             head_last;
    logic             pop;
    logic             issue;
    logic             abort;
    logic [2:0]       pending;

`ifdef CONV_ROM_READER_ABORT_EN
    assign abort = abort_i & (state_q == RUN);
`else
    assign abort = 1'b0;
`endif

    assign valid_o    = (occ != '0);
    assign pop        = valid_o & ready_i;
    assign data_o     = head_data;
    assign last_o     = valid_o & head_last;
    assign rom_addr_o = addr_q;

    // Words already buffered or on their way must leave room for one more read.
    assign pending = 3'({1'b0, occ}) + 3'(inflight_q);
    assign issue   = (state_q == RUN) && (words_left_q != '0) && (pending < 3'd2 + 3'(pop));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: defaulting state_d before the case keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = (length_i == '0) ? DONE : RUN;
            RUN: begin
                if (abort)                  state_d = IDLE;
                else if (pop && head_last)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            words_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue & ~abort;
            inflight_last_q <= issue && (words_left_q == LENW'(1));
            if (state_q == IDLE && start_i) begin
                addr_q       <= base_addr_i;
                words_left_q <= length_i;
            end else if (abort) begin
                words_left_q <= '0;
            end else if (issue) begin
                addr_q       <= addr_q + ADDRW'(1);
                words_left_q <= words_left_q - LENW'(1);
            end
        end
    end

    convolutor_rom_reader_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (inflight_q & ~abort),
        .push_last (inflight_last_q),
        .push_data (rom_data_i),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .occ       (occ)
    );

endmodule

// File: tb/tb_convolutor_rom_reader.sv
// Self-checking bench for convolutor_rom_reader: a ROM model plus a queue-based reference of expected words.
module tb_convolutor_rom_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDRW = 4;
    localparam int LENW  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [ADDRW-1:0] base_addr_i = '0;
    logic [LENW-1:0]  length_i = '0;
    logic             busy_o, done_o, valid_o, last_o;
    logic [ADDRW-1:0] rom_addr_o;
    logic [WIDTH-1:0] rom_data_i = '0;
    logic [WIDTH-1:0] data_o;
    logic             ready_i = 1'b0;
`ifdef CONV_ROM_READER_ABORT_EN
    logic             abort_i = 1'b0;
`endif

    logic [WIDTH-1:0] rom [DEPTH];
    bit               pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    convolutor_rom_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW), .LENW(LENW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
`ifdef CONV_ROM_READER_ABORT_EN
        .abort_i     (abort_i),
`endif
        .ready_i     (ready_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int idx);
        if (mode == 0)      return 1'b1;
        else if (mode == 1) return 1'($urandom_range(1));
        else                return pattern[idx % 6];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy_o),  0);
        check({tag, "_done"},  32'(done_o),  0);
        check({tag, "_valid"}, 32'(valid_o), 0);
        check({tag, "_last"},  32'(last_o),  0);
    endtask

    // One transfer: the expected words are the ROM contents at base, base+1, ... modulo DEPTH.
    task automatic xfer(input int base, input int len, input int mode);
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] pd;
        logic             pl;
        int  cyc = 0, first_v = -1, last_hs = -1, n_hs = 0, idx = 0;
        bit  done_seen = 0, stall = 0, hs;
        pd = '0;
        pl = 1'b0;
        for (int k = 0; k < len; k++) q.push_back(rom[(base + k) % DEPTH]);
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = ADDRW'(base);
        length_i    = LENW'(len);
        ready_i     = pick_ready(mode, idx++);
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            check("busy", 32'(busy_o), 1);
            if (stall) begin
                check("stall_valid", 32'(valid_o), 1);
                check("stall_data",  32'(data_o),  32'(pd));
                check("stall_last",  32'(last_o),  32'(pl));
            end
            if (done_o) begin
                done_seen = 1;
                check("done_timing", cyc, (len == 0) ? 1 : last_hs + 1);
                check("done_count",  n_hs, len);
            end
            if (valid_o && first_v < 0) first_v = cyc;
            // Inputs for the next edge; start_i while busy must be ignored.
            start_i     = done_seen ? 1'b0 : ($urandom_range(3) == 0);
            base_addr_i = ADDRW'($urandom);
            length_i    = LENW'($urandom);
            ready_i     = pick_ready(mode, idx++);
            hs    = valid_o && ready_i;
            stall = valid_o && !ready_i;
            pd    = data_o;
            pl    = last_o;
            if (valid_o) begin
                if (q.size() == 0) begin
                    check("extra_valid", 32'(valid_o), 0);
                end else begin
                    check("data", 32'(data_o), 32'(q[0]));
                    if (hs) begin
                        void'(q.pop_front());
                        n_hs++;
                        last_hs = cyc;
                        check("last", 32'(last_o), 32'(q.size() == 0));
                    end
                end
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        start_i = 1'b0;
        ready_i = 1'b0;
        if (mode == 0 && len > 0) check("first_valid", first_v, 3);
        @(negedge clk);
        check_idle_outputs("after_xfer");
    endtask

    task automatic reset_mid();
        int n_hs = 0, cyc = 0;
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = ADDRW'(5);
        length_i    = LENW'(8);
        ready_i     = 1'b1;
        while (n_hs < 2 && cyc < 50) begin
            @(negedge clk);
            start_i = 1'b0;
            cyc++;
            if (valid_o) n_hs++;
        end
        check("rst_reach_word3", 32'(n_hs), 2);
        @(negedge clk);
        check("rst_word3_valid", 32'(valid_o), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_data", 32'(data_o), 0);
        check("rst_mid_addr", 32'(rom_addr_o), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");
        xfer(11, 5, 0);
    endtask

`ifdef CONV_ROM_READER_ABORT_EN
    task automatic abort_test();
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = ADDRW'(2);
        length_i    = LENW'(8);
        ready_i     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        check("abort_pre_valid", 32'(valid_o), 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check_idle_outputs("abort");
        @(negedge clk);
        check_idle_outputs("abort_after");
        xfer(9, 6, 1);
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = WIDTH'($urandom);
        #1;
        check_idle_outputs("reset");
        check("reset_data", 32'(data_o), 0);
        check("reset_addr", 32'(rom_addr_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");

        xfer(3, 4, 0);
        xfer(14, 4, 0);
        xfer(2, 6, 2);
        xfer(7, 0, 0);
        xfer(9, 20, 1);
        xfer(0, 16, 0);
        for (int t = 0; t < 12; t++)
            xfer($urandom_range(DEPTH - 1), $urandom_range(31), $urandom_range(2));
        reset_mid();
`ifdef CONV_ROM_READER_ABORT_EN
        abort_test();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
